// File: rtl/instr_sequencer_if.sv
// Control/status bundle between the system controller and instr_sequencer.
// The step signal exists only when SINGLE_STEP_EN is defined.
interface instr_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
);
  // Handshake: start/halt are level samples taken on rising clk; a start is
  // accepted only while the sequencer is idle and halt is low (halt wins).
  // done, err and issue_stb are single-cycle pulses; all outputs are registered.
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] end_addr;
  logic              halt;
`ifdef SINGLE_STEP_EN
  logic              step;
`endif
  logic [ADDR_W-1:0] cur_add;
  logic              instr_valid;
  logic              issue_stb;
  logic              busy;
  logic              done;
  logic              err;
  logic [CNT_W-1:0]  issued_cnt;

  modport master (
    output start, start_addr, end_addr, halt,
`ifdef SINGLE_STEP_EN
    output step,
`endif
    input  cur_add, instr_valid, issue_stb, busy, done, err, issued_cnt
  );

  modport slave (
    input  start, start_addr, end_addr, halt,
`ifdef SINGLE_STEP_EN
    input  step,
`endif
    output cur_add, instr_valid, issue_stb, busy, done, err, issued_cnt
  );
endinterface

// File: rtl/instr_sequencer.sv
// Steps cur_add through [start_addr, end_addr], holding each address HOLD_CYC cycles.
// Optional SINGLE_STEP_EN adds a WAIT state that needs a step pulse between addresses.
module instr_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int HOLD_CYC = 5,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  instr_sequencer_if.slave bus,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
`ifdef SINGLE_STEP_EN
    , S_WAIT = 2'd3
`endif
  } state_t;

  localparam logic [7:0]       HOLD_LAST = 8'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [7:0]        hold_q, hold_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              stb_q, stb_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] cur_inc;
  logic [CNT_W-1:0]  cnt_inc;

  assign cur_inc = cur_q + ADDR_W'(1);
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      end_q   <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      end_q   <= end_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      stb_q   <= stb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    end_d   = end_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    stb_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.halt) begin
          if (bus.start_addr <= bus.end_addr) begin
            state_d = S_EXEC;
            cur_d   = bus.start_addr;
            end_d   = bus.end_addr;
            hold_d  = '0;
            cnt_d   = CNT_W'(1);
            stb_d   = 1'b1;
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_EXEC: begin
        if (bus.halt) begin
          state_d = S_IDLE;
          hold_d  = '0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          if (cur_q == end_q) begin
            state_d = S_DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
`ifdef SINGLE_STEP_EN
            // Park on the finished address until the controller steps.
            state_d = S_WAIT;
            valid_d = 1'b0;
`else
            cur_d = cur_inc;
            cnt_d = cnt_inc;
            stb_d = 1'b1;
`endif
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

`ifdef SINGLE_STEP_EN
      S_WAIT: begin
        if (bus.halt) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (bus.step) begin
          state_d = S_EXEC;
          cur_d   = cur_inc;
          cnt_d   = cnt_inc;
          hold_d  = '0;
          stb_d   = 1'b1;
          valid_d = 1'b1;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.cur_add     = cur_q;
  assign bus.instr_valid = valid_q;
  assign bus.issue_stb   = stb_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.issued_cnt  = cnt_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: IDLE request table, directed multi-cycle runs,
// async reset and randomized runs checked against a per-cycle expected trace.
module tb_instr_sequencer;
  localparam int ADDR_W  = 8;
  localparam int CNT_W   = 8;
  localparam int HOLD    = 5;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int REC_W   = ADDR_W + 5 + CNT_W;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] dbg_state;

  instr_sequencer_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  instr_sequencer #(.ADDR_W(ADDR_W), .HOLD_CYC(HOLD), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [REC_W-1:0]  exp_q[$];
  logic              step_q[$];
  logic [ADDR_W-1:0] last_add;
  logic [CNT_W-1:0]  last_cnt;

  typedef struct {
    bit                start;
    bit                halt;
    logic [ADDR_W-1:0] sa;
    logic [ADDR_W-1:0] ea;
    bit                busy;
    bit                err;
    logic [ADDR_W-1:0] add;
    logic [CNT_W-1:0]  cnt;
  } vec_t;

  vec_t vecs[9];

  // Record layout: {cur_add, instr_valid, issue_stb, busy, done, err, issued_cnt}
  function automatic logic [REC_W-1:0] rec(input logic [ADDR_W-1:0] a, input logic v,
                                           input logic stb, input logic b, input logic d,
                                           input logic e, input logic [CNT_W-1:0] c);
    return {a, v, stb, b, d, e, c};
  endfunction

  function automatic logic [REC_W-1:0] observed();
    return {bus.cur_add, bus.instr_valid, bus.issue_stb, bus.busy, bus.done, bus.err,
            bus.issued_cnt};
  endfunction

  task automatic check_rec(input string name, input logic [REC_W-1:0] act,
                           input logic [REC_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got add=%0d v=%0b stb=%0b busy=%0b done=%0b err=%0b cnt=%0d, want add=%0d v=%0b stb=%0b busy=%0b done=%0b err=%0b cnt=%0d",
               name, act[REC_W-1 -: ADDR_W], act[CNT_W+4], act[CNT_W+3], act[CNT_W+2],
               act[CNT_W+1], act[CNT_W], act[CNT_W-1:0],
               exp[REC_W-1 -: ADDR_W], exp[CNT_W+4], exp[CNT_W+3], exp[CNT_W+2],
               exp[CNT_W+1], exp[CNT_W], exp[CNT_W-1:0]);
    end
  endtask

  task automatic idle_inputs();
    bus.start      = 1'b0;
    bus.halt       = 1'b0;
    bus.start_addr = '0;
    bus.end_addr   = '0;
`ifdef SINGLE_STEP_EN
    bus.step       = 1'b0;
`endif
  endtask

  // ---------------- reference model + driver ----------------
  // Trace of one run, one record per cycle after the start sample edge:
  // each address is live for HOLD cycles (strobe on the first), optional
  // step waits between addresses, then either an abort or done + idle.
  // halt_at: -1 none, -2 random, otherwise the cycle index carrying halt.
  task automatic run_seq(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e,
                         input int halt_at, input int wait_max, input bit noise);
    int n;
    int h;
    logic [CNT_W-1:0]  c;
    logic [REC_W-1:0]  tmp;
    logic [ADDR_W-1:0] a;
    n = int'(e) - int'(s) + 1;
    h = halt_at;
    c = '0;
    exp_q.delete();
    step_q.delete();
    for (int k = 0; k < n; k++) begin
      a = ADDR_W'(int'(s) + k);
      c = (k + 1 > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(k + 1);
      for (int j = 0; j < HOLD; j++) begin
        exp_q.push_back(rec(a, 1'b1, j == 0, 1'b1, 1'b0, 1'b0, c));
        step_q.push_back(1'b0);
      end
`ifdef SINGLE_STEP_EN
      if (k < n - 1) begin
        int w;
        w = $urandom_range(1, wait_max);
        for (int i = 0; i < w; i++) begin
          exp_q.push_back(rec(a, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, c));
          step_q.push_back(i == w - 1);
        end
      end
`else
      if (wait_max < 0) c = '0;
`endif
    end
    if (h == -2) h = ($urandom_range(0, 1) == 1) ? $urandom_range(0, exp_q.size() - 1) : -1;
    if (h >= 0 && h < exp_q.size()) begin
      while (exp_q.size() > h + 1) begin
        void'(exp_q.pop_back());
        void'(step_q.pop_back());
      end
      tmp = exp_q[h];
      exp_q.push_back(rec(tmp[REC_W-1 -: ADDR_W], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tmp[CNT_W-1:0]));
      step_q.push_back(1'b0);
    end else begin
      h = -1;
      exp_q.push_back(rec(e, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, c));
      exp_q.push_back(rec(e, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c));
      step_q.push_back(1'b0);
      step_q.push_back(1'b0);
    end

    @(negedge clk);
    bus.start      = 1'b1;
    bus.start_addr = s;
    bus.end_addr   = e;
    bus.halt       = 1'b0;
    for (int t = 0; t < exp_q.size(); t++) begin
      bit last;
      @(negedge clk);
      check_rec($sformatf("run %0d..%0d halt@%0d t=%0d", s, e, h, t), observed(), exp_q[t]);
      last = (t == exp_q.size() - 1);
      bus.start = (!last && noise) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin
        bus.start_addr = ADDR_W'($urandom);
        bus.end_addr   = ADDR_W'($urandom);
      end
      bus.halt = (t == h);
`ifdef SINGLE_STEP_EN
      bus.step = step_q[t];
`endif
    end
    tmp      = exp_q[exp_q.size() - 1];
    last_add = tmp[REC_W-1 -: ADDR_W];
    last_cnt = tmp[CNT_W-1:0];
    idle_inputs();
  endtask

  // A start that must be refused: reversed range (err pulse) or halt alongside.
  task automatic reject_req(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e,
                            input bit h);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.start_addr = s;
    bus.end_addr   = e;
    bus.halt       = h;
    @(negedge clk);
    check_rec($sformatf("reject %0d..%0d halt=%0b", s, e, h), observed(),
              rec(last_add, 1'b0, 1'b0, 1'b0, 1'b0, !h, last_cnt));
    idle_inputs();
    @(negedge clk);
    check_rec($sformatf("reject %0d..%0d after", s, e), observed(),
              rec(last_add, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, last_cnt));
  endtask

  initial begin
    idle_inputs();

    // Reset state while rst is held low across clock edges.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_rec("reset held", observed(), '0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_rec("after reset release", observed(), '0);

    // IDLE request table.
    vecs[0] = '{1'b0, 1'b0, 8'd7,   8'd9,   1'b0, 1'b0, 8'd0,   8'd0};
    vecs[1] = '{1'b1, 1'b1, 8'd7,   8'd9,   1'b0, 1'b0, 8'd0,   8'd0};
    vecs[2] = '{1'b1, 1'b1, 8'd9,   8'd7,   1'b0, 1'b0, 8'd0,   8'd0};
    vecs[3] = '{1'b1, 1'b0, 8'd9,   8'd7,   1'b0, 1'b1, 8'd0,   8'd0};
    vecs[4] = '{1'b1, 1'b0, 8'd7,   8'd9,   1'b1, 1'b0, 8'd7,   8'd1};
    vecs[5] = '{1'b1, 1'b0, 8'd255, 8'd0,   1'b0, 1'b1, 8'd7,   8'd1};
    vecs[6] = '{1'b1, 1'b0, 8'd255, 8'd255, 1'b1, 1'b0, 8'd255, 8'd1};
    vecs[7] = '{1'b1, 1'b0, 8'd0,   8'd255, 1'b1, 1'b0, 8'd0,   8'd1};
    vecs[8] = '{1'b1, 1'b0, 8'd4,   8'd4,   1'b1, 1'b0, 8'd4,   8'd1};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus.start      = vecs[i].start;
      bus.halt       = vecs[i].halt;
      bus.start_addr = vecs[i].sa;
      bus.end_addr   = vecs[i].ea;
      @(negedge clk);
      check_rec($sformatf("vec %0d", i), observed(),
                rec(vecs[i].add, vecs[i].busy, vecs[i].busy, vecs[i].busy, 1'b0,
                    vecs[i].err, vecs[i].cnt));
      bus.start = 1'b0;
      bus.halt  = vecs[i].busy;
      @(negedge clk);
      check_rec($sformatf("vec %0d settle", i), observed(),
                rec(vecs[i].add, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, vecs[i].cnt));
      bus.halt = 1'b0;
    end
    last_add = 8'd4;
    last_cnt = 8'd1;

    // Directed multi-cycle runs.
    run_seq(8'd2, 8'd2, -1, 1, 1'b0);
    run_seq(8'd0, 8'd3, -1, 1, 1'b0);
    reject_req(8'd5, 8'd3, 1'b0);
    run_seq(8'd0, 8'd3, HOLD + 2, 1, 1'b0);
    run_seq(8'd0, 8'd1, -1, 3, 1'b0);
    reject_req(8'd9, 8'd9, 1'b1);
    run_seq(8'd0, 8'd255, -1, 1, 1'b0);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    bus.start      = 1'b1;
    bus.start_addr = 8'd10;
    bus.end_addr   = 8'd40;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_rec("async reset mid-run", observed(), '0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_rec("idle after async reset", observed(), '0);
    last_add = '0;
    last_cnt = '0;

    // Randomized runs with rejected starts, aborts and busy-time start noise.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 9) < 2) begin
        logic [ADDR_W-1:0] s;
        s = ADDR_W'($urandom_range(1, 255));
        reject_req(s, ADDR_W'($urandom_range(0, int'(s) - 1)), 1'($urandom_range(0, 1)));
      end else begin
        logic [ADDR_W-1:0] s;
        int len;
        s   = ADDR_W'($urandom_range(0, 255));
        len = $urandom_range(0, 3);
        if (int'(s) + len > 255) len = 255 - int'(s);
        run_seq(s, ADDR_W'(int'(s) + len), -2, 3, 1'b1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
